// File: rtl/endec_axis_bridge.sv
// AXI-Stream bridge between the host DMA and the endec core: assembles a 10-beat request
// frame into core fields, then streams the 11-beat core result back with tlast on the final beat.
module endec_axis_bridge #(
    parameter int DATA_W   = 64,
    parameter int RX_BEATS = 10,
    parameter int TX_BEATS = 11
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [DATA_W-1:0]          m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [26:0]                o_gen_poly_flat,
    output logic                       o_code_rate,
    output logic [7:0]                 o_prv_encoder_state,
    output logic [191:0]               o_encoder_data_frame,
    output logic [383:0]               o_decoder_data_frame,
    output logic                       o_core_start,
    input  logic                       i_core_done,
    input  logic [575:0]               i_encoder_data,
    input  logic [127:0]               i_decoder_data,
    output logic                       o_frame_err
);

    localparam int         RSP_W   = DATA_W * TX_BEATS;
    localparam int         MID_W   = DATA_W * (RX_BEATS - 2);
    localparam logic [3:0] RX_LAST = 4'(RX_BEATS - 1);
    localparam logic [3:0] TX_LAST = 4'(TX_BEATS - 1);

    typedef enum logic [2:0] {
        ST_RX,
        ST_DRAIN,
        ST_START,
        ST_WAIT,
        ST_TX
    } state_t;

    state_t             state, state_n;
    logic [3:0]         rx_cnt, tx_cnt;
    logic [35:0]        cfg_q;
    logic [MID_W-1:0]   data_q;
    logic [RSP_W-1:0]   rsp_r;
    logic               rx_fire, tx_fire, rx_at_last;
    logic               frame_ok, frame_err_n;

    // Beat 0 keeps only its config bits; beat 9 is consumed straight off the bus on load.
    always_comb begin
        state_n       = state;
        frame_ok      = 1'b0;
        frame_err_n   = 1'b0;
        s_axis_tready = (state == ST_RX) || (state == ST_DRAIN);
        m_axis_tvalid = (state == ST_TX);
        m_axis_tlast  = m_axis_tvalid && (tx_cnt == TX_LAST);
        rx_fire       = s_axis_tvalid && s_axis_tready;
        tx_fire       = m_axis_tvalid && m_axis_tready;
        rx_at_last    = (rx_cnt == RX_LAST);
        m_axis_tdata  = '0;
        for (int unsigned j = 0; j < TX_BEATS; j++) begin
            if (m_axis_tvalid && (tx_cnt == 4'(j))) begin
                m_axis_tdata = rsp_r[DATA_W*j +: DATA_W];
            end
        end

        case (state)
            ST_RX: begin
                if (rx_fire) begin
                    if (rx_at_last) begin
                        if (s_axis_tlast) begin
                            state_n  = ST_START;
                            frame_ok = 1'b1;
                        end else begin
                            state_n = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        frame_err_n = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (rx_fire && s_axis_tlast) begin
                    frame_err_n = 1'b1;
                    state_n     = ST_RX;
                end
            end
            ST_START: state_n = ST_WAIT;
            ST_WAIT: begin
                if (i_core_done) begin
                    state_n = ST_TX;
                end
            end
            ST_TX: begin
                if (tx_fire && (tx_cnt == TX_LAST)) begin
                    state_n = ST_RX;
                end
            end
            default: state_n = ST_RX;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= ST_RX;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rx_cnt               <= '0;
            tx_cnt               <= '0;
            cfg_q                <= '0;
            data_q               <= '0;
            rsp_r                <= '0;
            o_gen_poly_flat      <= '0;
            o_code_rate          <= 1'b0;
            o_prv_encoder_state  <= '0;
            o_encoder_data_frame <= '0;
            o_decoder_data_frame <= '0;
            o_core_start         <= 1'b0;
            o_frame_err          <= 1'b0;
        end else begin
            o_core_start <= frame_ok;
            o_frame_err  <= frame_err_n;

            if ((state == ST_RX) && rx_fire) begin
                if (rx_cnt == '0) begin
                    cfg_q <= s_axis_tdata[35:0];
                end
                for (int unsigned k = 1; k < RX_BEATS - 1; k++) begin
                    if (rx_cnt == 4'(k)) begin
                        data_q[DATA_W*(k-1) +: DATA_W] <= s_axis_tdata;
                    end
                end
                rx_cnt <= (s_axis_tlast || rx_at_last) ? '0 : rx_cnt + 4'd1;
            end

            if (frame_ok) begin
                o_gen_poly_flat      <= cfg_q[26:0];
                o_code_rate          <= cfg_q[27];
                o_prv_encoder_state  <= cfg_q[35:28];
                o_encoder_data_frame <= data_q[191:0];
                o_decoder_data_frame <= {s_axis_tdata, data_q[MID_W-1:192]};
            end

            if ((state == ST_WAIT) && i_core_done) begin
                rsp_r  <= {i_decoder_data, i_encoder_data};
                tx_cnt <= '0;
            end else if ((state == ST_TX) && tx_fire) begin
                tx_cnt <= (tx_cnt == TX_LAST) ? '0 : tx_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_endec_axis_bridge.sv
// Bench for endec_axis_bridge: table-driven frame shapes, hand-built corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_endec_axis_bridge;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic [63:0]   s_axis_tdata;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
    logic [63:0]   m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast;
    logic [26:0]   o_gen_poly_flat;
    logic          o_code_rate;
    logic [7:0]    o_prv_encoder_state;
    logic [191:0]  o_encoder_data_frame;
    logic [383:0]  o_decoder_data_frame;
    logic          o_core_start, i_core_done, o_frame_err;
    logic [575:0]  i_encoder_data;
    logic [127:0]  i_decoder_data;

    endec_axis_bridge #(.DATA_W(64), .RX_BEATS(10), .TX_BEATS(11)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .o_gen_poly_flat(o_gen_poly_flat), .o_code_rate(o_code_rate),
        .o_prv_encoder_state(o_prv_encoder_state),
        .o_encoder_data_frame(o_encoder_data_frame),
        .o_decoder_data_frame(o_decoder_data_frame),
        .o_core_start(o_core_start), .i_core_done(i_core_done),
        .i_encoder_data(i_encoder_data), .i_decoder_data(i_decoder_data),
        .o_frame_err(o_frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [703:0] got, input logic [703:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic chki(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Negedge monitor: pulse counting, accepted response beats and AXIS hold rule.
    int          start_cnt = 0;
    int          err_cnt = 0;
    logic [64:0] rsp_q[$];
    logic [63:0] prev_data;
    logic        prev_last;
    logic        prev_stall = 1'b0;

    always @(negedge sys_clk) begin
        if (o_core_start) start_cnt++;
        if (o_frame_err) err_cnt++;
        if (prev_stall && !rst)
            chk("axis_hold", 704'({m_axis_tvalid, m_axis_tlast, m_axis_tdata}),
                704'({1'b1, prev_last, prev_data}));
        prev_stall = m_axis_tvalid && !m_axis_tready && !rst;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        if (m_axis_tvalid && m_axis_tready && !rst)
            rsp_q.push_back({m_axis_tlast, m_axis_tdata});
    end

    logic [63:0] fb[16];
    logic        fl[16];

    // Frame-level reference: a frame completes only when exactly its 10th beat carries tlast.
    task automatic model_parse(input int n, output int st, output int er);
        int  pos = 0;
        bit  drain = 0;
        st = 0;
        er = 0;
        for (int k = 0; k < n; k++) begin
            if (drain) begin
                if (fl[k]) begin er++; drain = 0; end
            end else if (pos == 9) begin
                if (fl[k]) st++; else drain = 1;
                pos = 0;
            end else if (fl[k]) begin
                er++;
                pos = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic chk_fields();
        logic [639:0] f;
        for (int k = 0; k < 10; k++) f[64*k +: 64] = fb[k];
        chk("gen_poly", 704'(o_gen_poly_flat), 704'(f[26:0]));
        chk("code_rate", 704'(o_code_rate), 704'(f[27]));
        chk("prv_state", 704'(o_prv_encoder_state), 704'(f[35:28]));
        chk("enc_frame", 704'(o_encoder_data_frame), 704'(f[255:64]));
        chk("dec_frame", 704'(o_decoder_data_frame), 704'(f[639:256]));
    endtask

    task automatic send_beats(input int n, input int gap, output logic ls);
        bit ok;
        int t;
        for (int k = 0; k < n; k++) begin
            s_axis_tdata  = fb[k];
            s_axis_tlast  = fl[k];
            s_axis_tvalid = 1'b1;
            ok = 0;
            t  = 0;
            while (!ok && t < 200) begin
                @(negedge sys_clk);
                ok = s_axis_tready;
                step();
                t++;
            end
            if (!ok) chki("rx_accept_timeout", 0, 1);
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            if (k < n - 1) repeat (gap) step();
        end
        @(negedge sys_clk);
        ls = o_core_start;
        step();
    endtask

    function automatic logic rdy(input int mode, input int ph);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (ph % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic core_respond(input logic [575:0] enc, input logic [127:0] dec,
                                input int delay, input int mode, input int stop_at);
        logic [703:0] exp;
        int ph, t;
        exp = {dec, enc};
        repeat (delay) step();
        rsp_q.delete();
        i_encoder_data = enc;
        i_decoder_data = dec;
        i_core_done    = 1'b1;
        step();
        i_core_done    = 1'b0;
        i_encoder_data = '0;
        i_decoder_data = '0;
        ph = 0;
        m_axis_tready = rdy(mode, ph);
        @(negedge sys_clk);
        chki("tvalid_after_capture", int'(m_axis_tvalid), 1);
        t = 0;
        while (rsp_q.size() < stop_at && t < 300) begin
            step();
            t++;
            if (rsp_q.size() < stop_at) begin
                ph++;
                m_axis_tready = rdy(mode, ph);
            end
        end
        m_axis_tready = 1'b0;
        if (rsp_q.size() < stop_at) chki("tx_timeout", rsp_q.size(), stop_at);
        for (int j = 0; j < rsp_q.size(); j++)
            chk("rsp_beat", 704'(rsp_q[j]), 704'({(j == 10), exp[64*j +: 64]}));
        if (stop_at == 11) begin
            @(negedge sys_clk);
            chki("tx_end_tvalid", int'(m_axis_tvalid), 0);
            chki("tx_end_s_ready", int'(s_axis_tready), 1);
            step();
        end
    endtask

    task automatic rand_core(output logic [575:0] enc, output logic [127:0] dec);
        for (int i = 0; i < 18; i++) enc[32*i +: 32] = $urandom;
        for (int i = 0; i < 4; i++) dec[32*i +: 32] = $urandom;
    endtask

    typedef struct {
        int          n;
        logic [15:0] tmask;
        int          gap;
        int          rmode;
        int          exp_start;
        int          exp_err;
    } vec_t;

    vec_t         vecs[8];
    logic         ls;
    int           s0, e0, st, er, n;
    logic [575:0] enc;
    logic [127:0] dec;

    initial begin
        vecs[0] = '{10, 16'h0200, 0, 0, 1, 0};   // normal
        vecs[1] = '{10, 16'h0200, 0, 1, 1, 0};   // backpressure 1,0,0
        vecs[2] = '{10, 16'h0200, 3, 0, 1, 0};   // source gaps
        vecs[3] = '{5,  16'h0010, 0, 0, 0, 1};   // early tlast on beat 4
        vecs[4] = '{10, 16'h0200, 1, 2, 1, 0};   // clean frame after error
        vecs[5] = '{12, 16'h0800, 0, 0, 0, 1};   // missing tlast, drain 2
        vecs[6] = '{1,  16'h0001, 0, 0, 0, 1};   // single-beat frame
        vecs[7] = '{9,  16'h0100, 2, 0, 0, 1};   // tlast on beat 8

        rst = 1'b1;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        m_axis_tready = 1'b0; i_core_done = 1'b0;
        i_encoder_data = '0; i_decoder_data = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge sys_clk);
        chki("rst_m_tvalid", int'(m_axis_tvalid), 0);
        chki("rst_m_tlast", int'(m_axis_tlast), 0);
        chk("rst_m_tdata", 704'(m_axis_tdata), '0);
        chki("rst_core_start", int'(o_core_start), 0);
        chki("rst_frame_err", int'(o_frame_err), 0);
        chk("rst_gen_poly", 704'(o_gen_poly_flat), '0);
        chk("rst_dec_frame", 704'(o_decoder_data_frame), '0);
        chki("rst_s_ready", int'(s_axis_tready), 1);
        step();

        // Core done outside WAIT must not launch a response.
        i_core_done = 1'b1;
        step();
        i_core_done = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            chki("done_ignored_tvalid", int'(m_axis_tvalid), 0);
            step();
        end

        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                fb[k] = {$urandom, $urandom};
                fl[k] = vecs[i].tmask[k];
            end
            if (i == 0) fb[0] = {28'hABCDEF1, 8'h5A, 1'b1, 27'h4E6CDED};
            s0 = start_cnt;
            e0 = err_cnt;
            send_beats(vecs[i].n, vecs[i].gap, ls);
            chki("start_latency", int'(ls), vecs[i].exp_start);
            if (vecs[i].exp_start != 0) begin
                chk_fields();
                if (i == 0) begin
                    chk("gen_poly_const", 704'(o_gen_poly_flat), 704'(27'h4E6CDED));
                    enc = 576'h1;
                    dec = 128'h2;
                end else begin
                    rand_core(enc, dec);
                end
                core_respond(enc, dec, 2, vecs[i].rmode, 11);
            end
            repeat (3) step();
            chki("start_pulses", start_cnt - s0, vecs[i].exp_start);
            chki("err_pulses", err_cnt - e0, vecs[i].exp_err);
        end

        // Reset in the middle of a response: the rest of the response is dropped.
        for (int k = 0; k < 10; k++) begin
            fb[k] = {$urandom, $urandom};
            fl[k] = (k == 9);
        end
        send_beats(10, 0, ls);
        chki("rst_tx_start", int'(ls), 1);
        rand_core(enc, dec);
        core_respond(enc, dec, 1, 0, 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge sys_clk);
        chki("rst_tx_tvalid", int'(m_axis_tvalid), 0);
        chki("rst_tx_s_ready", int'(s_axis_tready), 1);
        chk("rst_tx_gen_poly", 704'(o_gen_poly_flat), '0);
        step();
        repeat (3) step();
        chki("rst_tx_no_more_beats", rsp_q.size(), 5);

        // Randomized frames against the reference model.
        for (int r = 0; r < 30; r++) begin
            n = ($urandom_range(0, 1) == 1) ? 10 : $urandom_range(1, 14);
            for (int k = 0; k < n; k++) begin
                fb[k] = {$urandom, $urandom};
                fl[k] = (k == n - 1);
            end
            model_parse(n, st, er);
            s0 = start_cnt;
            e0 = err_cnt;
            send_beats(n, $urandom_range(0, 2), ls);
            chki("rand_start_latency", int'(ls), st);
            if (st != 0) begin
                chk_fields();
                rand_core(enc, dec);
                core_respond(enc, dec, $urandom_range(0, 4), 2, 11);
            end
            repeat (3) step();
            chki("rand_start_pulses", start_cnt - s0, st);
            chki("rand_err_pulses", err_cnt - e0, er);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
